// File: rtl/isfet_pkg.sv
// Shared types and widths for the ISFET array scan controller.
package isfet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } scan_state_t;

    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/isfet_tick_gen.sv
// Rising-edge detector turning the divided clock into a one-cycle sample tick.
module isfet_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_div,
    output logic tick
);

    logic clk_div_q;
    logic clk_div_d;

    always_comb begin
        clk_div_d = clk_div;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_q <= 1'b0;
        end else begin
            clk_div_q <= clk_div_d;
        end
    end

    assign tick = clk_div & ~clk_div_q;

endmodule

// File: rtl/isfet_scan_ctrl.sv
// Raster scan of the ISFET array: settles each row, samples one pixel per tick
// and streams pixels out on a valid/ready handshake with sticky overrun.
module isfet_scan_ctrl
    import isfet_pkg::*;
#(
    parameter int unsigned ROWS   = 64,
    parameter int unsigned COLS   = 64,
    parameter int unsigned ADC_W  = 16,
    parameter int unsigned SETTLE = 4,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   clk_div,
    input  logic [ADC_W-1:0]       adc_data,
    output logic [ROW_W-1:0]       row_addr,
    output logic [COL_W-1:0]       col_addr,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [ADC_W-1:0]       pix_data,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic tick;

    scan_state_t            state_q,     state_d;
    logic [ROW_W-1:0]       row_q,       row_d;
    logic [COL_W-1:0]       col_q,       col_d;
    logic [SET_W-1:0]       set_cnt_q,   set_cnt_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [ADC_W-1:0]       pix_data_q,  pix_data_d;
    logic                   sof_q,       sof_d;
    logic                   eol_q,       eol_d;
    logic                   busy_q,      busy_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   overrun_q,   overrun_d;

    logic accept_c;
    logic last_col_c;
    logic last_row_c;
    logic last_set_c;

    isfet_tick_gen u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .tick    (tick)
    );

    // Next-state and datapath; enable low overrides everything as a synchronous abort.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        set_cnt_d   = set_cnt_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        accept_c   = pix_valid_q & pix_ready;
        last_col_c = (col_q == COL_W'(COLS - 32'd1));
        last_row_c = (row_q == ROW_W'(ROWS - 32'd1));
        last_set_c = (set_cnt_q == SET_W'(SETTLE - 32'd1));

        if (!enable) begin
            state_d     = ST_IDLE;
            pix_valid_d = 1'b0;
            row_d       = '0;
            col_d       = '0;
            set_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SETTLE;
                        row_d     = '0;
                        col_d     = '0;
                        set_cnt_d = '0;
                        overrun_d = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        if (last_set_c) begin
                            set_cnt_d = '0;
                            state_d   = ST_SAMPLE;
                        end else begin
                            set_cnt_d = set_cnt_q + SET_W'(1);
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (tick) begin
                        pix_data_d  = adc_data;
                        pix_valid_d = 1'b1;
                        sof_d       = (row_q == '0) && (col_q == '0);
                        eol_d       = last_col_c;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A tick coinciding with the accept is consumed, never sampled.
                    if (accept_c) begin
                        pix_valid_d = 1'b0;
                        if (!last_col_c) begin
                            col_d   = col_q + COL_W'(1);
                            state_d = ST_SAMPLE;
                        end else if (!last_row_c) begin
                            col_d     = '0;
                            row_d     = row_q + ROW_W'(1);
                            set_cnt_d = '0;
                            state_d   = ST_SETTLE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                            row_d       = '0;
                            col_d       = '0;
                            set_cnt_d   = '0;
                            state_d     = continuous ? ST_SETTLE : ST_IDLE;
                        end
                    end else if (tick) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    pix_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            set_cnt_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            set_cnt_q   <= set_cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign row_addr  = row_q;
    assign col_addr  = col_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_isfet_scan_ctrl.sv
// Bench for isfet_scan_ctrl: pixel-index / tick-count reference model compared every cycle.
module tb_isfet_scan_ctrl;

    localparam int unsigned ROWS   = 2;
    localparam int unsigned COLS   = 3;
    localparam int unsigned ADC_W  = 16;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NPIX   = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             start;
    logic             continuous;
    logic             clk_div;
    logic [ADC_W-1:0] adc_data;
    logic [0:0]       row_addr;
    logic [1:0]       col_addr;
    logic             pix_valid;
    logic             pix_ready;
    logic [ADC_W-1:0] pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             overrun;

    isfet_scan_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADC_W  (ADC_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .continuous (continuous),
        .clk_div    (clk_div),
        .adc_data   (adc_data),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame position as a flat pixel index plus ticks still owed before the next sample.
    logic        m_active = 1'b0;
    logic        m_wait   = 1'b0;
    logic        m_hold   = 1'b0;
    int          m_idx    = 0;
    int          m_left   = 0;
    logic        m_ov     = 1'b0;
    logic [15:0] m_frames = 16'd0;
    logic [15:0] m_data   = 16'd0;
    logic        m_sof    = 1'b0;
    logic        m_eol    = 1'b0;
    logic        m_div_prev = 1'b0;
    logic        m_tick;

    logic [15:0] obs_data[$];
    logic [1:0]  obs_flags[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_wait = 1'b0; m_hold = 1'b0;
            m_idx = 0; m_left = 0; m_ov = 1'b0; m_frames = 16'd0;
            m_div_prev = 1'b0;
        end else begin
            check("pix_valid", 32'(pix_valid), 32'(m_hold));
            check("busy",      32'(busy),      32'(m_active));
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            check("overrun",   32'(overrun),   32'(m_ov));
            check("row_addr",  32'(row_addr),  32'(m_idx / COLS));
            check("col_addr",  32'(col_addr),  32'(m_idx % COLS));
            if (m_hold) begin
                check("pix_data", 32'(pix_data), 32'(m_data));
                check("pix_sof",  32'(pix_sof),  32'(m_sof));
                check("pix_eol",  32'(pix_eol),  32'(m_eol));
            end
            if (pix_valid && pix_ready) begin
                obs_data.push_back(pix_data);
                obs_flags.push_back({pix_sof, pix_eol});
            end

            m_tick     = clk_div && !m_div_prev;
            m_div_prev = clk_div;
            if (!enable) begin
                m_active = 1'b0; m_wait = 1'b0; m_hold = 1'b0; m_idx = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_wait = 1'b1; m_hold = 1'b0;
                    m_idx = 0; m_left = SETTLE + 1; m_ov = 1'b0;
                end
            end else if (m_wait) begin
                if (m_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_wait = 1'b0; m_hold = 1'b1;
                        m_data = adc_data;
                        m_sof  = (m_idx == 0);
                        m_eol  = ((m_idx % COLS) == COLS - 1);
                    end
                end
            end else if (m_hold) begin
                if (pix_ready) begin
                    m_hold = 1'b0;
                    m_idx++;
                    if (m_idx == NPIX) begin
                        m_frames++;
                        m_idx = 0;
                        if (continuous) begin
                            m_wait = 1'b1; m_left = SETTLE + 1;
                        end else begin
                            m_active = 1'b0;
                        end
                    end else begin
                        m_wait = 1'b1;
                        m_left = ((m_idx % COLS) == 0) ? SETTLE + 1 : 1;
                    end
                end else if (m_tick) begin
                    m_ov = 1'b1;
                end
            end
        end
    end

    // Divider (N=1: clk_div period 4 clk), ready pattern and ADC stimulus.
    int   ready_mode = 0;
    int   data_mode  = 0;
    int   bp_left    = 0;
    logic bp_done    = 1'b0;
    int   div_cnt    = 0;
    logic div_prev   = 1'b0;

    initial begin
        clk_div   = 1'b0;
        pix_ready = 1'b0;
        adc_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            div_prev = clk_div;
            div_cnt++;
            if (div_cnt == 2) begin
                div_cnt = 0;
                clk_div = ~clk_div;
            end
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (m_hold && m_idx == 2 && !bp_done) begin
                        bp_done = 1'b1;
                        bp_left = 10;
                    end
                    if (bp_left > 0) begin
                        pix_ready = 1'b0;
                        bp_left--;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
                3: pix_ready = clk_div && !div_prev;
                default: pix_ready = 1'b0;
            endcase
            adc_data = (data_mode == 0) ? 16'(32'h0100 + m_idx) : 16'($urandom);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int i = 0;
        while (m_active && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("frame_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   32'(row_addr),  32'd0);
        check({tag, "_col"},   32'(col_addr),  32'd0);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_data"},  32'(pix_data),  32'd0);
        check({tag, "_sof"},   32'(pix_sof),   32'd0);
        check({tag, "_eol"},   32'(pix_eol),   32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_frame"}, 32'(frame_cnt), 32'd0);
        check({tag, "_ovr"},   32'(overrun),   32'd0);
    endtask

    task automatic check_ordered_frame(input string tag);
        check({tag, "_count"}, 32'(obs_data.size()), 32'(NPIX));
        for (int i = 0; i < NPIX && i < obs_data.size(); i++) begin
            check({tag, "_data"}, 32'(obs_data[i]), 32'h0100 + 32'(i));
            check({tag, "_flags"}, 32'(obs_flags[i]),
                  32'({(i == 0), ((i % COLS) == COLS - 1)}));
        end
    endtask

    initial begin
        int i;
        logic [15:0] fc_save;
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; continuous = 1'b0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; enable = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame, ready always high, data = 0x0100 + pixel index.
        ready_mode = 0; data_mode = 0;
        obs_data.delete(); obs_flags.delete();
        pulse_start();
        run_until_idle(500);
        check_ordered_frame("single");
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure on pixel 2 for 10 clk.
        ready_mode = 2; bp_done = 1'b0;
        obs_data.delete(); obs_flags.delete();
        pulse_start();
        run_until_idle(500);
        check_ordered_frame("bp");
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        // Every accept coincides with a tick: consumed, never an overrun.
        ready_mode = 3;
        obs_data.delete(); obs_flags.delete();
        pulse_start();
        run_until_idle(800);
        check_ordered_frame("tickacc");
        check("tickacc_overrun", 32'(overrun), 32'd0);
        check("tickacc_frame_cnt", 32'(frame_cnt), 32'd3);

        // Continuous for 3 frames with random ready and data.
        ready_mode = 1; data_mode = 1; continuous = 1'b1;
        obs_data.delete(); obs_flags.delete();
        pulse_start();
        i = 0;
        while (m_frames != 16'd5 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        #1 continuous = 1'b0;
        run_until_idle(1500);
        check("cont_frame_cnt", 32'(frame_cnt), 32'd6);
        check("cont_pixels", 32'(obs_data.size()), 32'(3 * NPIX));
        for (int k = 0; k < obs_flags.size(); k++) begin
            check("cont_sof", 32'(obs_flags[k][1]), 32'((k % NPIX) == 0));
        end

        // Abort while holding a pixel, then a fresh frame.
        ready_mode = 4; data_mode = 1;
        pulse_start();
        i = 0;
        while (!m_hold && i < 200) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("abort_reach_hold", 32'(pix_valid), 32'd1);
        fc_save = m_frames;
        enable = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(pix_valid), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'(fc_save));
        ready_mode = 0;
        pulse_start();
        run_until_idle(500);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd7);

        // Random ready/data with ignored start pulses while busy.
        ready_mode = 1; data_mode = 1;
        for (int f = 0; f < 4; f++) begin
            pulse_start();
            repeat ($urandom_range(3, 40)) @(posedge clk);
            pulse_start();
            run_until_idle(1500);
        end
        check("rand_frame_cnt", 32'(frame_cnt), 32'd11);

        // Asynchronous reset mid-row.
        ready_mode = 0;
        pulse_start();
        i = 0;
        while (!(m_wait && m_idx == 1) && i < 200) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Start with enable low is ignored.
        enable = 1'b0;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check("noenable_busy", 32'(busy), 32'd0);
        check("noenable_frame_cnt", 32'(frame_cnt), 32'd0);
        enable = 1'b1;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
